fifo_rd_stream_ctrl: RTL and testbench

Read-side drain stage that sits directly downstream of the FIFO data path, in the read clock domain. It issues pops to the FIFO, absorbs the one-cycle read latency of the dual-port RAM, and presents the words as a valid/ready stream through a small skid buffer. Throughput is one word per clock when the FIFO is non-empty and the sink is ready.

---
 rtl/fifo_rd_stream_ctrl.sv | 126 ++++++++++++
 tb/tb_fifo_rd_stream_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_stream_ctrl.sv
// fifo_rd_stream_ctrl: read-side drain stage for a FIFO with a one-cycle RAM
// read latency. It pops the FIFO on credit, catches the returning word in a
// small circular skid buffer and presents it as a valid/ready stream.
// Optional feature macro: FIFO_RD_STALL_CNT_EN adds a saturating stall_cnt
// output counting cycles where a word is offered but the sink is not ready.
module fifo_rd_stream_ctrl #(
  parameter int data_width = 4,
  parameter int skid_depth = 2,
  parameter int cnt_width  = 16
) (
  input  logic                                  rd_clk,
  input  logic                                  rst_n_in_rd,
  input  logic [data_width-1:0]                 fifo_data_in,
  input  logic                                  fifo_empty,
  input  logic                                  fifo_pop_on_empty_err,
  output logic                                  fifo_rd_en,
  output logic [data_width-1:0]                 out_data,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  input  logic                                  flush,
  output logic                                  underflow_err,
`ifdef FIFO_RD_STALL_CNT_EN
  output logic [cnt_width-1:0]                  stall_cnt,
`endif
  output logic [$clog2(skid_depth+1)-1:0]       occupancy
);

  localparam int occWidth    = $clog2(skid_depth + 1);
  localparam int ptrWidth    = (skid_depth > 1) ? $clog2(skid_depth) : 1;
  localparam int creditWidth = occWidth + 1;

  logic [data_width-1:0]  buf_q [skid_depth];
  logic [ptrWidth-1:0]    wr_ptr_q, wr_ptr_d;
  logic [ptrWidth-1:0]    rd_ptr_q, rd_ptr_d;
  logic [occWidth-1:0]    count_q, count_d;
  logic                   inflight_q;
  logic                   underflow_err_q;
  logic                   accept;
  logic                   wrEn;
  logic [creditWidth-1:0] creditSum;

  assign out_valid     = (count_q != '0);
  assign out_data      = buf_q[rd_ptr_q];
  assign occupancy     = count_q;
  assign underflow_err = underflow_err_q;
  assign accept        = out_valid & out_ready;
  assign wrEn          = inflight_q & ~flush;

  // Credit check: words held plus the one in flight, minus the one leaving
  // this cycle, must leave room so a new pop can never overflow the buffer.
  // Held low during reset so no pop can escape while state is being cleared.
  always_comb begin
    creditSum  = {1'b0, count_q} + creditWidth'(inflight_q) - creditWidth'(accept);
    fifo_rd_en = rst_n_in_rd & ~fifo_empty & ~flush
                 & (creditSum < creditWidth'(skid_depth));
  end

  // Next-state pointers and count for the circular buffer; a simultaneous
  // write and accept moves both pointers and leaves the count alone.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wrEn) begin
      wr_ptr_d = (wr_ptr_q == ptrWidth'(skid_depth - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (accept) begin
      rd_ptr_d = (rd_ptr_q == ptrWidth'(skid_depth - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
    if (wrEn && !accept) begin
      count_d = count_q + 1'b1;
    end else if (!wrEn && accept) begin
      count_d = count_q - 1'b1;
    end
  end

  // Buffer state, in-flight tracking and the sticky underflow flag. Flush
  // empties the buffer and drops the word returning this cycle; since pops
  // are suppressed during flush, nothing returns the cycle after either.
  always_ff @(posedge rd_clk or negedge rst_n_in_rd) begin
    if (!rst_n_in_rd) begin
      for (int i = 0; i < skid_depth; i++) begin
        buf_q[i] <= '0;
      end
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
      inflight_q      <= 1'b0;
      underflow_err_q <= 1'b0;
    end else begin
      inflight_q      <= fifo_rd_en;
      underflow_err_q <= underflow_err_q | (fifo_rd_en & fifo_empty)
                         | fifo_pop_on_empty_err;
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (wrEn) begin
          buf_q[wr_ptr_q] <= fifo_data_in;
        end
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        count_q  <= count_d;
      end
    end
  end

`ifdef FIFO_RD_STALL_CNT_EN
  logic [cnt_width-1:0] stall_cnt_q;

  assign stall_cnt = stall_cnt_q;

  // Saturating count of cycles where a word is offered but not taken.
  always_ff @(posedge rd_clk or negedge rst_n_in_rd) begin
    if (!rst_n_in_rd) begin
      stall_cnt_q <= '0;
    end else if (flush) begin
      stall_cnt_q <= '0;
    end else if (out_valid && !out_ready && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_rd_stream_ctrl.sv
// Directed testbench for fifo_rd_stream_ctrl with a behavioural FIFO model
// that returns popped words one cycle after fifo_rd_en.
module tb_fifo_rd_stream_ctrl;

  localparam int DW = 4;
  localparam int SD = 2;
  localparam int CW = 16;

  logic          rd_clk = 1'b0;
  logic          rst_n_in_rd;
  logic [DW-1:0] fifo_data_in;
  logic          fifo_empty;
  logic          fifo_pop_on_empty_err;
  logic          fifo_rd_en;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          flush;
  logic          underflow_err;
  logic [1:0]    occupancy;
`ifdef FIFO_RD_STALL_CNT_EN
  logic [CW-1:0] stall_cnt;
`endif

  int testsRun    = 0;
  int testsFailed = 0;

  logic [DW-1:0] fifoMem [256];
  int            wrIdx = 0;
  int            rdIdx = 0;

  fifo_rd_stream_ctrl #(
    .data_width(DW),
    .skid_depth(SD),
    .cnt_width (CW)
  ) dut (
    .rd_clk               (rd_clk),
    .rst_n_in_rd          (rst_n_in_rd),
    .fifo_data_in         (fifo_data_in),
    .fifo_empty           (fifo_empty),
    .fifo_pop_on_empty_err(fifo_pop_on_empty_err),
    .fifo_rd_en           (fifo_rd_en),
    .out_data             (out_data),
    .out_valid            (out_valid),
    .out_ready            (out_ready),
    .flush                (flush),
    .underflow_err        (underflow_err),
`ifdef FIFO_RD_STALL_CNT_EN
    .stall_cnt            (stall_cnt),
`endif
    .occupancy            (occupancy)
  );

  // Free-running read clock, 10 time units per period.
  always #5 rd_clk = ~rd_clk;

  assign fifo_empty = (rdIdx == wrIdx);

  // FIFO model: a pop returns its word on the following cycle.
  always @(posedge rd_clk or negedge rst_n_in_rd) begin
    if (!rst_n_in_rd) begin
      fifo_data_in <= '0;
    end else if (fifo_rd_en) begin
      fifo_data_in <= fifoMem[rdIdx];
      rdIdx        <= rdIdx + 1;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic ready, input logic fl);
    @(negedge rd_clk);
    out_ready = ready;
    flush     = fl;
    #1;
  endtask

  task automatic pushWord(input logic [DW-1:0] w);
    fifoMem[wrIdx] = w;
    wrIdx++;
  endtask

  task automatic streamWords(input int first, input int n, input bit randomReady);
    int            got = 0;
    logic [DW-1:0] expWord;
    expWord = DW'(first);
    for (int cyc = 0; cyc < 400 && got < n; cyc++) begin
      applyStimulus(randomReady ? 1'($urandom_range(0, 1)) : 1'b1, 1'b0);
      if (out_valid && out_ready) begin
        checkOutput("streamData", 32'(out_data), 32'(expWord));
        expWord++;
        got++;
      end
    end
    checkOutput("streamCount", got, n);
  endtask

  initial begin
    int got;
    int bubbles;

    rst_n_in_rd           = 1'b0;
    out_ready             = 1'b0;
    flush                 = 1'b0;
    fifo_pop_on_empty_err = 1'b0;

    // Reset with FIFO holding 0xA, then first-word latency.
    pushWord(4'hA);
    @(negedge rd_clk);
    #1;
    checkOutput("rstValid", 32'(out_valid), 0);
    checkOutput("rstData", 32'(out_data), 0);
    checkOutput("rstRdEn", 32'(fifo_rd_en), 0);
    checkOutput("rstOcc", 32'(occupancy), 0);
    checkOutput("rstErr", 32'(underflow_err), 0);
    @(negedge rd_clk);
    rst_n_in_rd = 1'b1;
    #1;
    checkOutput("rdEnAfterRelease", 32'(fifo_rd_en), 1);
    applyStimulus(1'b0, 1'b0);
    checkOutput("validInFlight", 32'(out_valid), 0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("firstValid", 32'(out_valid), 1);
    checkOutput("firstData", 32'(out_data), 32'hA);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("drainedValid", 32'(out_valid), 0);

    // Back-to-back streaming of 1..8 with no bubbles.
    for (int i = 1; i <= 8; i++) pushWord(DW'(i));
    got     = 0;
    bubbles = 0;
    for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
      applyStimulus(1'b1, 1'b0);
      if (out_valid) begin
        checkOutput("b2bData", 32'(out_data), 32'(got + 1));
        got++;
      end else if (got > 0) begin
        bubbles++;
      end
    end
    checkOutput("b2bCount", got, 8);
    checkOutput("b2bBubbles", bubbles, 0);
    checkOutput("emptyFlag", 32'(fifo_empty), 1);
    checkOutput("rdEnWhenEmpty", 32'(fifo_rd_en), 0);
    applyStimulus(1'b1, 1'b0);

    // Backpressure: buffer fills to two words and pops stop.
    out_ready = 1'b0;
    for (int i = 1; i <= 8; i++) pushWord(DW'(i));
    repeat (10) applyStimulus(1'b0, 1'b0);
    checkOutput("bpOcc", 32'(occupancy), 2);
    checkOutput("bpRdEn", 32'(fifo_rd_en), 0);
    checkOutput("bpValid", 32'(out_valid), 1);
    checkOutput("bpHeldData", 32'(out_data), 1);
    streamWords(1, 8, 1'b0);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);

    // Random ready over 0x0..0xF; pointers wrap many times.
    for (int i = 0; i < 16; i++) pushWord(DW'(i));
    streamWords(0, 16, 1'b1);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("randDrainOcc", 32'(occupancy), 0);

    // Flush with one word held and one in flight.
    out_ready = 1'b0;
    for (int i = 1; i <= 6; i++) pushWord(DW'(i));
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1);
    checkOutput("preFlushOcc", 32'(occupancy), 1);
    checkOutput("rdEnDuringFlush", 32'(fifo_rd_en), 0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("postFlushValid", 32'(out_valid), 0);
    checkOutput("postFlushOcc", 32'(occupancy), 0);
    streamWords(3, 4, 1'b0);
    applyStimulus(1'b1, 1'b0);

    // Sticky underflow error, cleared only by reset.
    checkOutput("errBefore", 32'(underflow_err), 0);
    @(negedge rd_clk);
    fifo_pop_on_empty_err = 1'b1;
    @(negedge rd_clk);
    fifo_pop_on_empty_err = 1'b0;
    #1;
    checkOutput("errSet", 32'(underflow_err), 1);
    repeat (3) applyStimulus(1'b1, 1'b0);
    checkOutput("errSticky", 32'(underflow_err), 1);
    @(negedge rd_clk);
    rst_n_in_rd = 1'b0;
    #1;
    checkOutput("errClearedByReset", 32'(underflow_err), 0);
    @(negedge rd_clk);
    rst_n_in_rd = 1'b1;

    // Stalled word is held; stall counter tracks stalled cycles.
    out_ready = 1'b0;
    pushWord(4'h5);
    for (int i = 0; i < 10 && !out_valid; i++) applyStimulus(1'b0, 1'b0);
    checkOutput("stallValid", 32'(out_valid), 1);
`ifdef FIFO_RD_STALL_CNT_EN
    checkOutput("stallCntStart", 32'(stall_cnt), 0);
`endif
    repeat (5) applyStimulus(1'b0, 1'b0);
    checkOutput("stallHeldData", 32'(out_data), 32'h5);
`ifdef FIFO_RD_STALL_CNT_EN
    checkOutput("stallCntFive", 32'(stall_cnt), 5);
`endif
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0);
    checkOutput("stallFlushOcc", 32'(occupancy), 0);
`ifdef FIFO_RD_STALL_CNT_EN
    checkOutput("stallCntFlushed", 32'(stall_cnt), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
